afifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the write port of the async FIFO (wclk domain) among NREQ requesters.

---
 rtl/afifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_afifo_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// afifo_wr_arbiter
//   Round-robin arbiter that shares the write port of an async FIFO (wclk
//   domain) among NREQ requesters. One requester at a time owns the port for a
//   locked burst. The burst ends on its last beat or after MAX_BURST beats.
//   The owner's data is muxed onto winc/wdata, and wfull backpressure is
//   honoured.
//
// Handshake: a beat moves from requester i to the FIFO in a cycle where
//   req_valid[i] && req_ready[i]. That is exactly the cycle where winc=1.
//   req_ready is asserted only toward the current owner, and only while
//   wfull=0. It does not depend on req_valid. Requesters hold req_data and
//   req_last stable while req_valid=1 and the beat has not been accepted.
//
// Ports
//   wclk       in   write-domain clock
//   wrstn      in   asynchronous reset, active-high
//   req_valid  in   [NREQ]        per-requester beat valid
//   req_data   in   [NREQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   req_last   in   [NREQ]        final beat of the requester's burst
//   req_ready  out  [NREQ]        per-requester beat accept (one-hot or zero)
//   wfull      in   FIFO full flag
//   winc       out  FIFO write strobe
//   wdata      out  [WIDTH]       FIFO write data
//   grant_id   out  [clog2(NREQ)] current / last owner
//   busy       out  FSM state: 1 while a burst is granted (BURST)
// -----------------------------------------------------------------------------
module afifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8,
  localparam int IDW      = $clog2(NREQ),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WIDTH-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [CW-1:0]  LAST_CNT  = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] PTR_RESET = IDW'(NREQ - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IDW-1:0] pick;
  logic           beat;

  // Round-robin search. It starts just after the last finished owner, so
  // that owner gets the lowest priority in this arbitration.
  always_comb begin
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or posedge wrstn) begin
    if (wrstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    wdata     = '0;
    beat      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready[owner_q] = ~wfull;
        wdata              = req_data[owner_q*WIDTH +: WIDTH];
        beat               = req_valid[owner_q] & ~wfull;
        // The owner keeps the grant while stalled or idle: the burst is locked.
        if (beat) begin
          cnt_d = cnt_q + CW'(1);
          if (req_last[owner_q] || (cnt_q == LAST_CNT)) begin
            ptr_d   = owner_q;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign winc     = beat;
  assign grant_id = owner_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
module tb_afifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MAX_BURST = 8;
  localparam int W = 2 + WIDTH;   // {grant id, data}

  // ---------------- clock / reset ----------------
  logic                  wclk = 1'b0;
  logic                  wrstn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [WIDTH-1:0]      wdata;
  logic [1:0]            grant_id;
  logic                  busy;

  always #5 wclk = ~wclk;

  afifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrstn(wrstn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int wcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- requester model ----------------
  logic [WIDTH-1:0] mem_d [NREQ][32];
  logic             mem_l [NREQ][32];
  int               head [NREQ];
  int               tail [NREQ];
  logic [NREQ-1:0]  hold;

  function automatic void refresh();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i] && !hold[i]) begin
        req_valid[i]               = 1'b1;
        req_data[i*WIDTH +: WIDTH] = mem_d[i][head[i]];
        req_last[i]                = mem_l[i][head[i]];
      end else begin
        req_valid[i]               = 1'b0;
        req_data[i*WIDTH +: WIDTH] = '0;
        req_last[i]                = 1'b0;
      end
    end
  endfunction

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) p = 1'b1;
    return p;
  endfunction

  function automatic void flush();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic push(input int id, input logic [WIDTH-1:0] d, input logic last, input logic expect_write);
    mem_d[id][tail[id]] = d;
    mem_l[id][tail[id]] = last;
    tail[id]++;
    if (expect_write) exp_q.push_back({2'(id), d});
  endtask

  always @(negedge wclk) begin
    logic [W-1:0] e;
    if (winc === 1'b1) begin
      wcnt++;
      if (exp_q.size() == 0) check("spurious_winc", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wdata", wdata, e[WIDTH-1:0]);
        check("wr_grant_id", grant_id, e[W-1:WIDTH]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock: accepts are sampled at the negedge, and requesters advance just after the posedge.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge wclk);
    acc = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) head[i]++;
    refresh();
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || pending()) && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, busy | pending()}, 0);
  endtask

  task automatic pulse_reset();
    @(posedge wclk);
    #1 wrstn = 1'b1;
    repeat (2) @(posedge wclk);
    #1 wrstn = 1'b0;
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int w0;
    wrstn = 1'b1;
    wfull = 1'b0;
    hold  = '0;
    flush();
    refresh();
    repeat (3) @(posedge wclk);
    #2;
    check("rst_winc", winc, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wdata", wdata, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    #1 wrstn = 1'b0;

    // 1: single requester, three beats
    w0 = wcnt;
    push(1, 8'hA1, 0, 1); push(1, 8'hA2, 0, 1); push(1, 8'hA3, 1, 1);
    refresh();
    #1 check("t1_bubble_winc", winc, 0);
    step();
    check("t1_busy", busy, 1);
    check("t1_grant", grant_id, 1);
    check("t1_winc", winc, 1);
    check("t1_ready", req_ready, 4'b0010);
    repeat (3) step();
    check("t1_idle", busy, 0);
    check("t1_grant_hold", grant_id, 1);
    check("t1_writes", wcnt - w0, 3);

    // 2: all requesters, one-beat bursts, from a fresh pointer
    pulse_reset();
    w0 = wcnt;
    push(0, 8'h10, 1, 1); push(1, 8'h20, 1, 1); push(2, 8'h30, 1, 1);
    push(3, 8'h40, 1, 1); push(0, 8'h11, 1, 1);
    refresh();
    step();
    check("t2_first_grant", grant_id, 0);
    repeat (9) step();
    check("t2_writes", wcnt - w0, 5);
    check("t2_idle", busy, 0);

    // 3: forced burst end at MAX_BURST; req0 wins next
    w0 = wcnt;
    push(0, 8'h60, 1, 0);
    for (int i = 0; i < 12; i++) push(2, 8'(8'h50 + i), (i == 11), (i < 8));
    exp_q.push_back({2'd0, 8'h60});
    for (int i = 8; i < 12; i++) exp_q.push_back({2'd2, 8'(8'h50 + i)});
    refresh();
    step();
    check("t3_grant", grant_id, 2);
    repeat (8) step();
    check("t3_forced_idle", busy, 0);
    check("t3_writes", wcnt - w0, 8);
    step();
    check("t3_next_grant", grant_id, 0);
    wait_idle(40);

    // 4: wfull stall mid-burst
    w0 = wcnt;
    for (int i = 0; i < 6; i++) push(3, 8'(8'h70 + i), (i == 5), 1);
    refresh();
    repeat (3) step();
    wfull = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("t4_stall_winc", winc, 0);
      check("t4_stall_ready", req_ready, 0);
      check("t4_stall_grant", grant_id, 3);
      step();
    end
    wfull = 1'b0;
    wait_idle(40);
    check("t4_writes", wcnt - w0, 6);

    // 5: owner drops valid mid-burst while req0 waits
    push(0, 8'h80, 1, 1);
    refresh();
    wait_idle(10);
    for (int i = 0; i < 4; i++) push(1, 8'(8'h90 + i), (i == 3), 1);
    push(0, 8'h81, 1, 1);
    refresh();
    repeat (3) step();
    hold[1] = 1'b1;
    refresh();
    #1;
    for (int c = 0; c < 3; c++) begin
      check("t5_gap_winc", winc, 0);
      check("t5_gap_grant", grant_id, 1);
      check("t5_gap_ready", req_ready, 4'b0010);
      step();
    end
    hold[1] = 1'b0;
    refresh();
    wait_idle(40);

    // 6: reset during an active burst
    for (int i = 0; i < 5; i++) push(2, 8'(8'hA0 + i), (i == 4), (i < 2));
    refresh();
    repeat (3) step();
    check("t6_pre_busy", busy, 1);
    wrstn = 1'b1;
    #1;
    check("t6_rst_winc", winc, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_grant", grant_id, 0);
    flush();
    refresh();
    @(posedge wclk);
    #1 wrstn = 1'b0;
    push(3, 8'hC3, 1, 1); push(0, 8'hC0, 1, 0);
    exp_q.push_front({2'd0, 8'hC0});
    refresh();
    step();
    check("t6_restart_grant", grant_id, 0);
    wait_idle(20);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
